// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between CPU (r0) and debug (r1), registered response, flag masking; optional grant counters under ALU_ARB_STATS_EN
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int FS_W   = 5,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_valid,
  input  logic [DATA_W-1:0] r0_S,
  input  logic [DATA_W-1:0] r0_T,
  input  logic [FS_W-1:0]   r0_FS,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [DATA_W-1:0] r1_S,
  input  logic [DATA_W-1:0] r1_T,
  input  logic [FS_W-1:0]   r1_FS,
  output logic              r1_ready,
  output logic [DATA_W-1:0] alu_S,
  output logic [DATA_W-1:0] alu_T,
  output logic [FS_W-1:0]   alu_FS,
  input  logic [DATA_W-1:0] alu_Y,
  input  logic              alu_V,
  input  logic              alu_C,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_Y,
  output logic              rsp_V,
  output logic              rsp_C,
  input  logic              rsp_ready
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [FS_W-1:0] FS_02 = FS_W'(8'h02);
  localparam logic [FS_W-1:0] FS_05 = FS_W'(8'h05);
  localparam logic [FS_W-1:0] FS_0C = FS_W'(8'h0C);
  localparam logic [FS_W-1:0] FS_0F = FS_W'(8'h0F);
  localparam logic [FS_W-1:0] FS_12 = FS_W'(8'h12);
  state_t state, state_nx;
  logic last_grant, pick1, acc, id_q, v_pass, c_pass, arith;
  logic [DATA_W-1:0] s_q, t_q;
  logic [FS_W-1:0] fs_q;
  // r1 wins when it is the only requester or when r0 was served last
  assign pick1    = r1_valid & (~r0_valid | ~last_grant);
  assign acc      = (state == IDLE) & (r0_valid | r1_valid);
  assign r0_ready = (state == IDLE) & r0_valid & ~pick1;
  assign r1_ready = (state == IDLE) & pick1;
  assign alu_S    = s_q;
  assign alu_T    = t_q;
  assign alu_FS   = fs_q;
  // the ALU leaves flags undefined outside these function ranges
  assign arith  = (fs_q >= FS_02 && fs_q <= FS_05) || (fs_q >= FS_0F && fs_q <= FS_12);
  assign v_pass = arith;
  assign c_pass = arith || (fs_q >= FS_0C && fs_q < FS_0F);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (acc ? EXEC : IDLE) :
               (state == EXEC) ? RESP :
               (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      s_q        <= '0;
      t_q        <= '0;
      fs_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_Y      <= '0;
      rsp_V      <= 1'b0;
      rsp_C      <= 1'b0;
    end else begin
      if (acc) begin
        s_q        <= pick1 ? r1_S : r0_S;
        t_q        <= pick1 ? r1_T : r0_T;
        fs_q       <= pick1 ? r1_FS : r0_FS;
        id_q       <= pick1;
        last_grant <= pick1;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_Y     <= alu_Y;
        rsp_V     <= v_pass ? alu_V : 1'b0;
        rsp_C     <= c_pass ? alu_C : 1'b0;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (r0_ready && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + STAT_W'(1);
      if (r1_ready && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + STAT_W'(1);
    end
  end
`else
  logic [STAT_W-1:0] unused_stat;
  assign unused_stat = '0;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed self-checking bench with a transaction-level reference model
module tb_alu_share_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic r0_valid = 0, r1_valid = 0, r0_ready, r1_ready;
  logic [31:0] r0_S = 0, r0_T = 0, r1_S = 0, r1_T = 0;
  logic [4:0] r0_FS = 0, r1_FS = 0;
  logic [31:0] alu_S, alu_T, alu_Y, rsp_Y;
  logic [4:0] alu_FS;
  logic alu_V, alu_C, rsp_valid, rsp_id, rsp_V, rsp_C;
  logic rsp_ready = 1'b1;
`ifdef ALU_ARB_STATS_EN
  logic [3:0] grant_cnt0, grant_cnt1;
`endif
  int cyc = 0, n_chk = 0, n_fail = 0;

  alu_share_arbiter #(.DATA_W(32), .FS_W(5), .STAT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_S(r0_S), .r0_T(r0_T), .r0_FS(r0_FS), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_S(r1_S), .r1_T(r1_T), .r1_FS(r1_FS), .r1_ready(r1_ready),
    .alu_S(alu_S), .alu_T(alu_T), .alu_FS(alu_FS), .alu_Y(alu_Y), .alu_V(alu_V), .alu_C(alu_C),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_Y(rsp_Y), .rsp_V(rsp_V), .rsp_C(rsp_C),
    .rsp_ready(rsp_ready)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in ALU; flags it does not define are driven 1 so a missing mask shows up
  function automatic logic [33:0] ref_alu(input logic [31:0] s, input logic [31:0] t, input logic [4:0] fs);
    logic [32:0] w;
    logic [31:0] y;
    logic v, c;
    v = 1'b1;
    c = 1'b1;
    y = s ^ t;
    case (fs)
      5'h00: y = s;
      5'h02: begin w = {1'b0, s} + {1'b0, t}; y = w[31:0]; c = w[32]; v = (s[31] == t[31]) && (y[31] != s[31]); end
      5'h04: begin y = s - t; c = s < t; v = (s[31] != t[31]) && (y[31] != s[31]); end
      5'h08: y = s & t;
      5'h0C: begin y = t << 1; c = t[31]; end
      default: ;
    endcase
    return {v, c, y};
  endfunction

  always_comb {alu_V, alu_C, alu_Y} = ref_alu(alu_S, alu_T, alu_FS);

  function automatic bit vflag_ok(input logic [4:0] fs);
    return fs inside {[5'h02:5'h05], [5'h0F:5'h12]};
  endfunction
  function automatic bit cflag_ok(input logic [4:0] fs);
    return fs inside {[5'h02:5'h05], [5'h0C:5'h0E], [5'h0F:5'h12]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // transaction model: one op in flight, response due the cycle after the op
  bit m_busy, m_rsp, m_last = 1'b1, m_pid, m_rid, m_pV, m_pC, m_rV, m_rC;
  logic [31:0] m_S, m_T, m_pY, m_rY;
  logic [4:0] m_FS;
  always @(negedge clk) begin
    bit idle, w1, e0, e1;
    logic [33:0] r;
    if (!reset_n) begin
      m_busy = 0; m_rsp = 0; m_last = 1; m_S = 0; m_T = 0; m_FS = 0;
      m_rid = 0; m_rY = 0; m_rV = 0; m_rC = 0;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_Y", rsp_Y, 0);
      check("rst_alu_S", alu_S, 0);
      check("rst_alu_FS", alu_FS, 0);
    end else begin
      idle = !m_busy && !m_rsp;
      w1 = r1_valid && (!r0_valid || !m_last);
      e0 = idle && r0_valid && !w1;
      e1 = idle && w1;
      check("r0_ready", r0_ready, e0);
      check("r1_ready", r1_ready, e1);
      check("rsp_valid", rsp_valid, m_rsp);
      check("rsp_id", rsp_id, m_rid);
      check("rsp_Y", rsp_Y, m_rY);
      check("rsp_V", rsp_V, m_rV);
      check("rsp_C", rsp_C, m_rC);
      check("alu_S", alu_S, m_S);
      check("alu_T", alu_T, m_T);
      check("alu_FS", alu_FS, m_FS);
      if (e0 || e1) begin
        m_S = e1 ? r1_S : r0_S;
        m_T = e1 ? r1_T : r0_T;
        m_FS = e1 ? r1_FS : r0_FS;
        r = ref_alu(m_S, m_T, m_FS);
        m_pY = r[31:0];
        m_pV = r[33] && vflag_ok(m_FS);
        m_pC = r[32] && cflag_ok(m_FS);
        m_pid = e1;
        m_last = e1;
        m_busy = 1;
      end else if (m_busy) begin
        m_busy = 0; m_rsp = 1; m_rid = m_pid; m_rY = m_pY; m_rV = m_pV; m_rC = m_pC;
      end else if (m_rsp && rsp_ready) m_rsp = 0;
    end
  end

  task automatic send(input bit id, input logic [31:0] s, input logic [31:0] t, input logic [4:0] fs, output int ac);
    ac = -1;
    if (id) begin r1_S = s; r1_T = t; r1_FS = fs; r1_valid = 1; end
    else begin r0_S = s; r0_T = t; r0_FS = fs; r0_valid = 1; end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (id ? r1_ready : r0_ready) begin ac = cyc; break; end
    end
    @(posedge clk); #1;
    if (id) r1_valid = 0; else r0_valid = 0;
    check("accept_seen", ac >= 0, 1);
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) begin rc = cyc; break; end
    end
    check("rsp_seen", rc >= 0, 1);
  endtask

  task automatic expect_rsp(input string n, input bit id, input logic [31:0] y, input bit v, input bit c);
    check({n, "_id"}, rsp_id, id);
    check({n, "_Y"}, rsp_Y, y);
    check({n, "_V"}, rsp_V, v);
    check({n, "_C"}, rsp_C, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r;
    int ord[$];
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_alu_T", alu_T, 0);
    reset_n = 1;
    @(posedge clk); #1;
    send(0, 32'h7FFFFFFF, 32'h00000001, 5'h02, a);
    wait_rsp(r);
    check("add_latency", r - a, 2);
    expect_rsp("add", 0, 32'h80000000, 1, 0);
    send(1, 32'hF0F0F0F0, 32'hFFFF0000, 5'h08, a);
    wait_rsp(r);
    expect_rsp("and", 1, 32'hF0F00000, 0, 0);
    send(1, 32'hF0F0F0F0, 32'h80000001, 5'h0C, a);
    wait_rsp(r);
    expect_rsp("sll", 1, 32'h00000002, 0, 1);
    send(1, 32'h12345678, 32'hFFFF0000, 5'h1F, a);
    wait_rsp(r);
    expect_rsp("fs1f", 1, 32'hEDCB5678, 0, 0);
    @(posedge clk); #1;
    r0_S = 32'd10; r0_T = 32'd3; r0_FS = 5'h02; r1_S = 32'd9; r1_T = 32'd4; r1_FS = 5'h04;
    r0_valid = 1; r1_valid = 1;
    for (int i = 0; i < 40 && ord.size() < 4; i++) begin
      @(negedge clk);
      check("both_ready", r0_ready & r1_ready, 0);
      if (r0_ready) ord.push_back(0);
      else if (r1_ready) ord.push_back(1);
    end
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0;
    check("rr_count", ord.size(), 4);
    check("rr_0", ord.size() > 0 ? ord[0] : 9, 0);
    check("rr_1", ord.size() > 1 ? ord[1] : 9, 1);
    check("rr_2", ord.size() > 2 ? ord[2] : 9, 0);
    check("rr_3", ord.size() > 3 ? ord[3] : 9, 1);
    wait_rsp(r);
    expect_rsp("rr_last", 1, 32'd5, 0, 0);
    @(posedge clk); #1;
    rsp_ready = 0;
    r1_S = 32'd1; r1_T = 32'd1; r1_FS = 5'h02; r1_valid = 1;
    send(0, 32'd5, 32'd7, 5'h04, a);
    wait_rsp(r);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      expect_rsp("bp", 0, 32'hFFFFFFFE, 0, 1);
      check("bp_r0_ready", r0_ready, 0);
      check("bp_r1_ready", r1_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    check("bp_hs_r1_ready", r1_ready, 0);
    @(negedge clk);
    check("bp_next_r1_ready", r1_ready, 1);
    @(posedge clk); #1;
    r1_valid = 0;
    wait_rsp(r);
    expect_rsp("bp_after", 1, 32'd2, 0, 0);
    @(posedge clk); #1;
    send(0, 32'd1, 32'd2, 5'h02, a);
    reset_n = 0;
    #1;
    check("rst_exec_valid", rsp_valid, 0);
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    check("rst_exec_noresp", rsp_valid, 0);
    @(posedge clk); #1;
    r0_S = 32'd3; r0_T = 32'd4; r0_FS = 5'h02; r1_S = 32'd8; r1_T = 32'd8; r1_FS = 5'h08;
    r0_valid = 1; r1_valid = 1;
    @(negedge clk);
    check("rst_first_r0", r0_ready, 1);
    check("rst_first_r1", r1_ready, 0);
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0;
    wait_rsp(r);
    expect_rsp("rst_after", 0, 32'd7, 0, 0);
    @(posedge clk); #1;
    rsp_ready = 0;
    send(1, 32'hAAAA0000, 32'h0000AAAA, 5'h08, a);
    wait_rsp(r);
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    check("rst_resp_valid", rsp_valid, 0);
    check("rst_resp_Y", rsp_Y, 0);
    @(posedge clk); #1;
    reset_n = 1;
    rsp_ready = 1;
    @(negedge clk);
    check("rst_resp_noresp", rsp_valid, 0);
`ifdef ALU_ARB_STATS_EN
    check("stat_rst0", grant_cnt0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 17; k++) begin
      send(0, k, 1, 5'h02, a);
      wait_rsp(r);
    end
    @(negedge clk);
    check("stat_cnt0", grant_cnt0, 4'hF);
    check("stat_cnt1", grant_cnt1, 4'h0);
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
